// File: rtl/hiscore_pkg.sv
// Shared types and constants for the high-score save/restore controller.
package hiscore_pkg;

  localparam int unsigned ADDR_W       = 10;
  localparam logic [7:0]  HI_INDEX_DEF = 8'd4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARMED,
    CHECK,
    WRITE,
    DONE,
    UPLOAD
  } state_t;

  // Game-RAM addresses wrap within the 1 KiB window.
  function automatic logic [ADDR_W-1:0] hs_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [ADDR_W-1:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/hiscore_restore_ctrl_if.sv
// Bundle of hps_io ioctl signals and the shared game-RAM port.
interface hiscore_restore_ctrl_if;
  import hiscore_pkg::*;

  logic              ioctl_download;
  logic              ioctl_upload;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_index;
  logic [7:0]        ioctl_din;
  logic              vblank;
  logic [7:0]        ram_din;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_dout;
  logic              ram_we;
  logic              ram_own;
  logic              pause_cpu;
  logic              restored;
  logic              timed_out;

  modport master (
    input  ioctl_download, ioctl_upload, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  vblank, ram_din,
    output ioctl_din, ram_addr, ram_dout, ram_we, ram_own, pause_cpu, restored, timed_out
  );

  modport slave (
    output ioctl_download, ioctl_upload, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output vblank, ram_din,
    input  ioctl_din, ram_addr, ram_dout, ram_we, ram_own, pause_cpu, restored, timed_out
  );

endinterface

// File: rtl/hiscore_buf.sv
// 1024x8 simple dual-port buffer holding the downloaded score table.
module hiscore_buf
  import hiscore_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hiscore_restore_ctrl.sv
// Arbitrates the centipede game-RAM port between the CPU and high-score
// download capture, vblank-time restore and upload readback.
module hiscore_restore_ctrl
  import hiscore_pkg::*;
#(
  parameter logic [7:0]        HI_INDEX    = HI_INDEX_DEF,
  parameter logic [ADDR_W-1:0] HS_BASE     = 10'h000,
  parameter logic [10:0]       HS_LEN      = 11'd64,
  parameter logic [7:0]        CHK_START   = 8'h00,
  parameter logic [7:0]        CHK_END     = 8'h00,
  parameter logic [7:0]        TIMEOUT_FRM = 8'd120
) (
  input logic                    clk,
  input logic                    reset,
  hiscore_restore_ctrl_if.master bus
);

  state_t            state, state_nx, ret_state, ret_nx;
  logic [7:0]        frm_cnt, frm_nx;
  logic [10:0]       cnt, cnt_nx;
  logic              buf_valid, buf_valid_nx;
  logic              wrote_any, wrote_nx;
  logic              restored_q, restored_nx;
  logic              timed_out_q, timed_out_nx;
  logic              vblank_d, up_oor_d;
  logic [7:0]        ioctl_din_q;

  logic              own_c, pause_c, we_c;
  logic [ADDR_W-1:0] addr_c, buf_raddr;
  logic [7:0]        dout_c, buf_rdata;

  logic              hi_sel, dl_req, up_req, vb_rise, in_table, buf_we;
  logic [ADDR_W-1:0] end_addr;

  assign hi_sel   = (bus.ioctl_index == HI_INDEX);
  assign dl_req   = bus.ioctl_download && hi_sel;
  assign up_req   = bus.ioctl_upload && hi_sel;
  assign vb_rise  = bus.vblank && !vblank_d;
  assign in_table = (bus.ioctl_addr < {14'd0, HS_LEN});
  assign buf_we   = (state == LOAD) && bus.ioctl_download && bus.ioctl_wr && in_table;
  assign end_addr = hs_addr(HS_BASE, HS_LEN[ADDR_W-1:0] - 10'd1);

  hiscore_buf u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (bus.ioctl_addr[ADDR_W-1:0]),
    .wdata (bus.ioctl_dout),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ret_state   <= IDLE;
      frm_cnt     <= '0;
      cnt         <= '0;
      buf_valid   <= 1'b0;
      wrote_any   <= 1'b0;
      restored_q  <= 1'b0;
      timed_out_q <= 1'b0;
      vblank_d    <= 1'b0;
      up_oor_d    <= 1'b0;
      ioctl_din_q <= '0;
    end else begin
      state       <= state_nx;
      ret_state   <= ret_nx;
      frm_cnt     <= frm_nx;
      cnt         <= cnt_nx;
      buf_valid   <= buf_valid_nx;
      wrote_any   <= wrote_nx;
      restored_q  <= restored_nx;
      timed_out_q <= timed_out_nx;
      vblank_d    <= bus.vblank;
      // Range flag is delayed to line up with the RAM's read latency.
      up_oor_d    <= !in_table;
      ioctl_din_q <= (state == UPLOAD && !up_oor_d) ? bus.ram_din : '0;
    end
  end

  always_comb begin
    state_nx     = state;
    ret_nx       = ret_state;
    frm_nx       = frm_cnt;
    cnt_nx       = cnt;
    buf_valid_nx = buf_valid;
    wrote_nx     = wrote_any | buf_we;
    restored_nx  = restored_q;
    timed_out_nx = timed_out_q;
    own_c        = 1'b0;
    pause_c      = 1'b0;
    we_c         = 1'b0;
    addr_c       = '0;
    dout_c       = '0;
    buf_raddr    = '0;

    // A fresh high-score download pre-empts everything except an active capture/upload.
    if (dl_req && state != LOAD && state != UPLOAD) begin
      state_nx     = LOAD;
      wrote_nx     = 1'b0;
      buf_valid_nx = 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (up_req) begin
            state_nx = UPLOAD;
            ret_nx   = state;
          end
        end
        LOAD: begin
          if (!bus.ioctl_download) begin
            if (wrote_any) begin
              state_nx     = ARMED;
              buf_valid_nx = 1'b1;
              frm_nx       = '0;
            end else begin
              state_nx = IDLE;
            end
          end
        end
        ARMED: begin
          if (frm_cnt == TIMEOUT_FRM) begin
            timed_out_nx = 1'b1;
            buf_valid_nx = 1'b0;
            state_nx     = IDLE;
          end else if (vb_rise && buf_valid) begin
            frm_nx   = frm_cnt + 8'd1;
            cnt_nx   = '0;
            state_nx = CHECK;
          end
        end
        CHECK: begin
          own_c   = 1'b1;
          pause_c = 1'b1;
          addr_c  = (cnt < 11'd2) ? HS_BASE : end_addr;
          cnt_nx  = cnt + 11'd1;
          // buf_raddr stays 0 here, so the final check cycle prefetches byte 0.
          if (cnt == 11'd2 && bus.ram_din != CHK_START) begin
            state_nx = ARMED;
          end else if (cnt == 11'd4) begin
            cnt_nx   = '0;
            state_nx = (bus.ram_din == CHK_END) ? WRITE : ARMED;
          end
        end
        WRITE: begin
          own_c     = 1'b1;
          pause_c   = 1'b1;
          we_c      = 1'b1;
          addr_c    = hs_addr(HS_BASE, cnt[ADDR_W-1:0]);
          dout_c    = buf_rdata;
          buf_raddr = cnt[ADDR_W-1:0] + 10'd1;
          cnt_nx    = cnt + 11'd1;
          if (cnt == HS_LEN - 11'd1) begin
            restored_nx  = 1'b1;
            buf_valid_nx = 1'b0;
            state_nx     = DONE;
          end
        end
        UPLOAD: begin
          own_c  = 1'b1;
          addr_c = hs_addr(HS_BASE, bus.ioctl_addr[ADDR_W-1:0]);
          if (!bus.ioctl_upload) state_nx = ret_state;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign bus.ram_own   = own_c;
  assign bus.pause_cpu = pause_c;
  assign bus.ram_we    = we_c & own_c;
  assign bus.ram_addr  = addr_c;
  assign bus.ram_dout  = dout_c;
  assign bus.ioctl_din = ioctl_din_q;
  assign bus.restored  = restored_q;
  assign bus.timed_out = timed_out_q;

endmodule
